// File: rtl/if_inst_queue.sv
// Fetch-to-decode instruction queue: a FIFO of tagged instructions with a registered head.
// Optional macro INST_QUEUE_BYPASS_EN sends a push into an empty, ready queue straight to decode in the same cycle.
module if_inst_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     fetch_valid_i,
    input  logic [XLEN-1:0]          fetch_pc_i,
    input  logic [31:0]              fetch_inst_i,
    input  logic                     fetch_ex_valid_i,
    input  logic [XLEN-1:0]          fetch_ex_cause_i,
    output logic                     fetch_ready_o,
    output logic                     dec_valid_o,
    output logic [XLEN-1:0]          dec_pc_o,
    output logic [31:0]              dec_inst_o,
    output logic                     dec_ex_valid_o,
    output logic [XLEN-1:0]          dec_ex_cause_o,
    input  logic                     dec_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]   FULL_COUNT    = CW'(DEPTH);
    localparam logic [XLEN-1:0] CAUSE_NONE    = XLEN'(8'hFF);
    localparam logic [XLEN-1:0] CAUSE_MISALGN = XLEN'(8'h00);
    localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(8'h02);

    logic [XLEN-1:0] pcMem_q    [DEPTH];
    logic [31:0]     instMem_q  [DEPTH];
    logic            exvMem_q   [DEPTH];
    logic [XLEN-1:0] causeMem_q [DEPTH];

    logic [PW-1:0]   rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] headPc_q, headPc_d, headCause_q, headCause_d;
    logic [31:0]     headInst_q, headInst_d;
    logic            headExv_q, headExv_d;

    logic            opLegal, inExv;
    logic [XLEN-1:0] inCause;
    logic            empty, pushAcc, popStored, store, bypass;
    logic [PW-1:0]   rdNext;

    // Exception tag computed once at push time; highest-priority source wins.
    always_comb begin
        opLegal = 1'b0;
        case (fetch_inst_i[6:0])
            7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h2F,
            7'h33, 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73: opLegal = 1'b1;
            default: opLegal = 1'b0;
        endcase
        inExv   = 1'b1;
        inCause = CAUSE_NONE;
        if (fetch_ex_valid_i) begin
            inCause = fetch_ex_cause_i;
        end else if (fetch_pc_i[1:0] != 2'b00) begin
            inCause = CAUSE_MISALGN;
        end else if (!opLegal) begin
            inCause = CAUSE_ILLEGAL;
        end else begin
            inExv = 1'b0;
        end
    end

    assign empty         = (count_q == '0);
    assign fetch_ready_o = (count_q != FULL_COUNT) && !flush_i;
    assign pushAcc       = fetch_valid_i && fetch_ready_o;
    assign popStored     = !empty && !flush_i && dec_ready_i;
`ifdef INST_QUEUE_BYPASS_EN
    assign bypass = empty && fetch_valid_i && dec_ready_i && !flush_i;
`else
    assign bypass = 1'b0;
`endif
    assign store  = pushAcc && !bypass;
    assign rdNext = rdPtr_q + PW'(1);

    // The head register always mirrors the entry at the read pointer, and simply
    // keeps its old contents whenever the queue drains or is flushed.
    always_comb begin
        rdPtr_d     = rdPtr_q;
        wrPtr_d     = wrPtr_q;
        count_d     = count_q;
        headPc_d    = headPc_q;
        headInst_d  = headInst_q;
        headExv_d   = headExv_q;
        headCause_d = headCause_q;
        if (flush_i) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (store)     wrPtr_d = wrPtr_q + PW'(1);
            if (popStored) rdPtr_d = rdNext;
            count_d = count_q + CW'(store) - CW'(popStored);
            if (bypass || (store && (empty || (popStored && count_q == CW'(1))))) begin
                headPc_d    = fetch_pc_i;
                headInst_d  = fetch_inst_i;
                headExv_d   = inExv;
                headCause_d = inCause;
            end else if (popStored && count_q >= CW'(2)) begin
                headPc_d    = pcMem_q[rdNext];
                headInst_d  = instMem_q[rdNext];
                headExv_d   = exvMem_q[rdNext];
                headCause_d = causeMem_q[rdNext];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            count_q     <= '0;
            headPc_q    <= '0;
            headInst_q  <= '0;
            headExv_q   <= 1'b0;
            headCause_q <= CAUSE_NONE;
        end else begin
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            count_q     <= count_d;
            headPc_q    <= headPc_d;
            headInst_q  <= headInst_d;
            headExv_q   <= headExv_d;
            headCause_q <= headCause_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (store && !flush_i) begin
            pcMem_q[wrPtr_q]    <= fetch_pc_i;
            instMem_q[wrPtr_q]  <= fetch_inst_i;
            exvMem_q[wrPtr_q]   <= inExv;
            causeMem_q[wrPtr_q] <= inCause;
        end
    end

    assign count_o     = count_q;
    assign dec_valid_o = (!empty && !flush_i) || bypass;
`ifdef INST_QUEUE_BYPASS_EN
    assign dec_pc_o       = bypass ? fetch_pc_i   : headPc_q;
    assign dec_inst_o     = bypass ? fetch_inst_i : headInst_q;
    assign dec_ex_valid_o = bypass ? inExv        : headExv_q;
    assign dec_ex_cause_o = bypass ? inCause      : headCause_q;
`else
    assign dec_pc_o       = headPc_q;
    assign dec_inst_o     = headInst_q;
    assign dec_ex_valid_o = headExv_q;
    assign dec_ex_cause_o = headCause_q;
`endif

endmodule

// File: tb/tb_if_inst_queue.sv
// Self-checking bench for if_inst_queue: directed scenarios plus randomized traffic against a queue model.
// Honours INST_QUEUE_BYPASS_EN when the design is built with it.
module tb_if_inst_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
`ifdef INST_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        exv;
        logic [63:0] cause;
    } entry_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        fetch_valid_i = 1'b0;
    logic [63:0] fetch_pc_i = '0;
    logic [31:0] fetch_inst_i = '0;
    logic        fetch_ex_valid_i = 1'b0;
    logic [63:0] fetch_ex_cause_i = '0;
    logic        dec_ready_i = 1'b0;
    logic        fetch_ready_o, dec_valid_o, dec_ex_valid_o;
    logic [63:0] dec_pc_o, dec_ex_cause_o;
    logic [31:0] dec_inst_o;
    logic [2:0]  count_o;

    int testsRun = 0;
    int testsFailed = 0;

    entry_t modelQ[$];
    entry_t lastHead = '0;

    logic [6:0] legalOps [14] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h2F,
                                  7'h33, 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};
    logic [6:0] illegalOps [6] = '{7'h7F, 7'h00, 7'h0B, 7'h2B, 7'h5B, 7'h7B};

    if_inst_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i), .fetch_inst_i(fetch_inst_i),
        .fetch_ex_valid_i(fetch_ex_valid_i), .fetch_ex_cause_i(fetch_ex_cause_i),
        .fetch_ready_o(fetch_ready_o), .dec_valid_o(dec_valid_o), .dec_pc_o(dec_pc_o),
        .dec_inst_o(dec_inst_o), .dec_ex_valid_o(dec_ex_valid_o), .dec_ex_cause_o(dec_ex_cause_o),
        .dec_ready_i(dec_ready_i), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic entry_t tagOf(input logic [63:0] pc, input logic [31:0] inst,
                                     input logic exv, input logic [63:0] cause);
        entry_t e;
        logic legal;
        e.pc   = pc;
        e.inst = inst;
        legal  = 1'b0;
        foreach (legalOps[k]) if (inst[6:0] == legalOps[k]) legal = 1'b1;
        if (exv)                 begin e.exv = 1'b1; e.cause = cause;  end
        else if (pc[1:0] != 0)   begin e.exv = 1'b1; e.cause = 64'h00; end
        else if (!legal)         begin e.exv = 1'b1; e.cause = 64'h02; end
        else                     begin e.exv = 1'b0; e.cause = 64'hFF; end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic fv, input logic [63:0] pc, input logic [31:0] inst,
                                 input logic exv, input logic [63:0] cause,
                                 input logic rdy, input logic fl);
        fetch_valid_i    = fv;
        fetch_pc_i       = pc;
        fetch_inst_i     = inst;
        fetch_ex_valid_i = exv;
        fetch_ex_cause_i = cause;
        dec_ready_i      = rdy;
        flush_i          = fl;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: a plain FIFO of tagged entries updated on each accepted edge.
    always @(posedge clk_i or posedge rst_i) begin
        entry_t incoming;
        bit popNow, pushNow;
        if (rst_i) begin
            modelQ.delete();
            lastHead = '0;
            lastHead.cause = 64'hFF;
        end else if (flush_i) begin
            if (modelQ.size() > 0) lastHead = modelQ[0];
            modelQ.delete();
        end else begin
            incoming = tagOf(fetch_pc_i, fetch_inst_i, fetch_ex_valid_i, fetch_ex_cause_i);
            if (BYPASS && modelQ.size() == 0 && fetch_valid_i && dec_ready_i) begin
                lastHead = incoming;
            end else begin
                popNow  = (modelQ.size() > 0) && dec_ready_i;
                pushNow = fetch_valid_i && (modelQ.size() != DEPTH);
                if (popNow)  lastHead = modelQ.pop_front();
                if (pushNow) modelQ.push_back(incoming);
            end
        end
    end

    always @(negedge clk_i) begin
        bit expBypass, expValid;
        entry_t expHead;
        if (!rst_i) begin
            expBypass = BYPASS && modelQ.size() == 0 && fetch_valid_i && dec_ready_i && !flush_i;
            expValid  = (modelQ.size() > 0 && !flush_i) || expBypass;
            if (modelQ.size() > 0) expHead = modelQ[0];
            else if (expBypass)    expHead = tagOf(fetch_pc_i, fetch_inst_i, fetch_ex_valid_i, fetch_ex_cause_i);
            else                   expHead = lastHead;
            checkOutput("model.count", 64'(count_o), 64'(modelQ.size()));
            checkOutput("model.fetch_ready", 64'(fetch_ready_o), 64'(modelQ.size() != DEPTH && !flush_i));
            checkOutput("model.dec_valid", 64'(dec_valid_o), 64'(expValid));
            checkOutput("model.dec_pc", dec_pc_o, expHead.pc);
            checkOutput("model.dec_inst", 64'(dec_inst_o), 64'(expHead.inst));
            checkOutput("model.dec_cause", dec_ex_cause_o, expHead.cause);
            if (expValid) checkOutput("model.dec_ex_valid", 64'(dec_ex_valid_o), 64'(expHead.exv));
        end
    end

    initial begin
        logic [63:0] pcR;
        logic [31:0] instR;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("reset.count", 64'(count_o), 64'd0);
        checkOutput("reset.dec_valid", 64'(dec_valid_o), 64'd0);
        checkOutput("reset.fetch_ready", 64'(fetch_ready_o), 64'd1);
        checkOutput("reset.dec_pc", dec_pc_o, 64'd0);
        checkOutput("reset.dec_inst", 64'(dec_inst_o), 64'd0);
        checkOutput("reset.dec_ex_valid", 64'(dec_ex_valid_o), 64'd0);
        checkOutput("reset.dec_cause", dec_ex_cause_o, 64'hFF);
        tick();

        // Fill with four ADDIs while decode stalls, then drain in order.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 64'h1000 + 64'(4 * i), 32'h00000013, 0, 0, 0, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        checkOutput("fill.count", 64'(count_o), 64'd4);
        checkOutput("fill.fetch_ready", 64'(fetch_ready_o), 64'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0);
            @(negedge clk_i);
            checkOutput("drain.dec_pc", dec_pc_o, 64'h1000 + 64'(4 * i));
            checkOutput("drain.dec_cause", dec_ex_cause_o, 64'hFF);
            tick();
        end

        // Exception tagging priority.
        applyStimulus(1, 64'h1002, 32'h00000013, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        @(negedge clk_i);
        checkOutput("misalign.ex_valid", 64'(dec_ex_valid_o), 64'd1);
        checkOutput("misalign.cause", dec_ex_cause_o, 64'h00);
        tick();
        applyStimulus(1, 64'h2000, 32'h0000007F, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        @(negedge clk_i);
        checkOutput("illegal.cause", dec_ex_cause_o, 64'h02);
        tick();
        applyStimulus(1, 64'h1002, 32'h00000013, 1, 64'h01, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        @(negedge clk_i);
        checkOutput("fetchfault.cause", dec_ex_cause_o, 64'h01);
        tick();

        // Flush with simultaneous push and pop loses everything.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 64'h3000 + 64'(4 * i), 32'h00000033, 0, 0, 0, 0);
            tick();
        end
        applyStimulus(1, 64'h3008, 32'h00000033, 0, 0, 1, 1);
        @(negedge clk_i);
        checkOutput("flush.dec_valid_during", 64'(dec_valid_o), 64'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        checkOutput("flush.count_after", 64'(count_o), 64'd0);
        checkOutput("flush.dec_valid_after", 64'(dec_valid_o), 64'd0);
        tick();
        applyStimulus(1, 64'h4000, 32'h00000033, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        checkOutput("postflush.dec_pc", dec_pc_o, 64'h4000);
        checkOutput("postflush.count", 64'(count_o), 64'd1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        tick();

        // Full queue: pop proceeds, push is refused.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 64'h5000 + 64'(4 * i), 32'h00000037, 0, 0, 0, 0);
            tick();
        end
        applyStimulus(1, 64'h6000, 32'h00000037, 0, 0, 1, 0);
        @(negedge clk_i);
        checkOutput("full.fetch_ready", 64'(fetch_ready_o), 64'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        checkOutput("full.count_after_pop", 64'(count_o), 64'd3);
        checkOutput("full.head_after_pop", dec_pc_o, 64'h5004);
        tick();
        for (int i = 1; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0);
            @(negedge clk_i);
            checkOutput("full.drain_pc", dec_pc_o, 64'h5000 + 64'(4 * i));
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        checkOutput("full.no_extra", 64'(count_o), 64'd0);
        tick();

        // Nine back-to-back pushes with decode always ready, across the pointer wrap.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 64'h7000 + 64'(4 * i), 32'h0000006F, 0, 0, 1, 0);
            @(negedge clk_i);
`ifdef INST_QUEUE_BYPASS_EN
            checkOutput("stream.bypass_pc", dec_pc_o, 64'h7000 + 64'(4 * i));
            checkOutput("stream.bypass_count", 64'(count_o), 64'd0);
`else
            if (i > 0) begin
                checkOutput("stream.pc", dec_pc_o, 64'h7000 + 64'(4 * (i - 1)));
                checkOutput("stream.count", 64'(count_o), 64'd1);
            end
`endif
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        @(negedge clk_i);
        checkOutput("stream.last_pc", dec_pc_o, 64'h7020);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Asynchronous reset between edges with three entries queued.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 64'h9000 + 64'(4 * i), 32'h00000003, 0, 0, 0, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        checkOutput("asyncrst.dec_valid", 64'(dec_valid_o), 64'd0);
        checkOutput("asyncrst.count", 64'(count_o), 64'd0);
        checkOutput("asyncrst.cause", dec_ex_cause_o, 64'hFF);
        #1 rst_i = 1'b0;
        tick();
        applyStimulus(1, 64'h8000, 32'h00000013, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        checkOutput("asyncrst.first_head", dec_pc_o, 64'h8000);
        checkOutput("asyncrst.first_count", 64'(count_o), 64'd1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        tick();

        // Randomized traffic; the negedge compare checks every cycle.
        for (int n = 0; n < 600; n++) begin
            pcR = {$urandom(), $urandom()};
            if ($urandom_range(3) != 0) pcR[1:0] = 2'b00;
            instR = $urandom();
            if ($urandom_range(4) != 0) instR[6:0] = legalOps[$urandom_range(13)];
            else                        instR[6:0] = illegalOps[$urandom_range(5)];
            applyStimulus($urandom_range(3) != 0, pcR, instR, $urandom_range(9) == 0,
                          64'($urandom_range(15)), ((n / 40) % 2 == 0) ? ($urandom_range(3) == 0) : ($urandom_range(2) != 0),
                          $urandom_range(24) == 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
